// File: rtl/prbs_pkg.sv
// Shared PRBS31 constants and checker state encoding, common to generator and checker.
package prbs_pkg;

  localparam int unsigned PRBS31_LEN   = 31;
  localparam int unsigned PRBS31_TAP_A = 27;
  localparam int unsigned PRBS31_TAP_B = 30;

  typedef enum logic [1:0] {
    SEED,
    VERIFY,
    LOCKED
  } prbs_state_e;

endpackage

// File: rtl/prbs31_predictor.sv
// PRBS31 history register and next-bit predictor.
// h[0] holds the newest valid bit; the prediction for the next bit is h[27] ^ h[30].
module prbs31_predictor
  import prbs_pkg::*;
(
  input  logic clk,
  input  logic rst_n,     // active-high asynchronous reset
  input  logic shift_en,
  input  logic din,
  output logic pred,
  output logic zero_next  // history would be all zeros after this shift
);

  logic [PRBS31_LEN-1:0] hist_q;
  logic [PRBS31_LEN-1:0] hist_d;
  logic [PRBS31_LEN-1:0] hist_shift;

  // Shift the incoming bit in at h[0] on valid cycles only.
  always_comb begin
    hist_shift = {hist_q[PRBS31_LEN-2:0], din};
    hist_d     = shift_en ? hist_shift : hist_q;
    pred       = hist_q[PRBS31_TAP_A] ^ hist_q[PRBS31_TAP_B];
    zero_next  = ~|hist_shift;
  end

  // History register.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end

endmodule

// File: rtl/prbs31_checker.sv
// Self-synchronising PRBS31 checker: seeds from the stream, verifies LOCK_THRESH predictions,
// then counts bit errors while locked and drops lock on too many errors within a window.
module prbs31_checker
  import prbs_pkg::*;
#(
  parameter int unsigned LOCK_THRESH = 64,
  parameter int unsigned WIN_LEN     = 256,
  parameter int unsigned LOSS_THRESH = 8,
  parameter int unsigned ERR_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,      // active-high asynchronous reset
  input  logic             din,
  input  logic             din_valid,
  input  logic             err_clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count
);

  localparam int unsigned WinW  = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam int unsigned WErrW = $clog2(LOSS_THRESH + 1);

  localparam logic [4:0]       FillLast = 5'(PRBS31_LEN - 1);
  localparam logic [7:0]       GoodLast = 8'(LOCK_THRESH - 1);
  localparam logic [WinW-1:0]  WinLast  = WinW'(WIN_LEN - 1);
  localparam logic [WErrW-1:0] LossLast = WErrW'(LOSS_THRESH - 1);

  prbs_state_e      state_q, state_d;
  logic [4:0]       fill_q, fill_d;
  logic [7:0]       good_q, good_d;
  logic [WinW-1:0]  win_q, win_d;
  logic [WErrW-1:0] werr_q, werr_d;
  logic             err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;

  logic pred;
  logic zero_next;
  logic mismatch;
  logic err_inc;

  prbs31_predictor u_predictor (
    .clk       (clk),
    .rst_n     (rst_n),
    .shift_en  (din_valid),
    .din       (din),
    .pred      (pred),
    .zero_next (zero_next)
  );

  assign mismatch = din ^ pred;

  // FSM state register.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and counter updates; invalid cycles leave everything untouched.
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    good_d  = good_q;
    win_d   = win_q;
    werr_d  = werr_q;
    err_inc = 1'b0;
    if (din_valid) begin
      unique case (state_q)
        SEED: begin
          if (fill_q == FillLast) begin
            state_d = VERIFY;
            good_d  = '0;
          end else begin
            fill_d = fill_q + 5'd1;
          end
        end
        VERIFY: begin
          if (mismatch) begin
            // History is kept; just rebuild confidence from scratch.
            state_d = SEED;
            fill_d  = '0;
          end else if (good_q == GoodLast) begin
            good_d = '0;
            if (zero_next) begin
              // An all-zero history trivially predicts itself; never lock on it.
              state_d = SEED;
              fill_d  = '0;
            end else begin
              state_d = LOCKED;
              win_d   = '0;
              werr_d  = '0;
            end
          end else begin
            good_d = good_q + 8'd1;
          end
        end
        LOCKED: begin
          err_inc = mismatch;
          if (mismatch && (werr_q == LossLast)) begin
            state_d = SEED;
            fill_d  = '0;
          end else if (win_q == WinLast) begin
            win_d  = '0;
            werr_d = '0;
          end else begin
            win_d  = win_q + 1'b1;
            werr_d = werr_q + WErrW'(mismatch);
          end
        end
        default: begin
          state_d = SEED;
          fill_d  = '0;
        end
      endcase
    end

    err_pulse_d = err_inc;
    if (err_clr) begin
      err_count_d = '0;
    end else if (err_inc && !(&err_count_q)) begin
      err_count_d = err_count_q + 1'b1;
    end else begin
      err_count_d = err_count_q;
    end
  end

  // Counter and error-output registers.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      fill_q      <= '0;
      good_q      <= '0;
      win_q       <= '0;
      werr_q      <= '0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      fill_q      <= fill_d;
      good_q      <= good_d;
      win_q       <= win_d;
      werr_q      <= werr_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    locked    = (state_q == LOCKED);
    err_pulse = err_pulse_q;
    err_count = err_count_q;
  end

endmodule

// File: tb/tb_prbs31_checker.sv
// Scoreboard bench for prbs31_checker: two instances (default, and ERR_W=4 with
// LOSS_THRESH=WIN_LEN) share one stimulus stream; a reference model pushes expected outputs
// per cycle and a monitor compares them after each rising edge.
module tb_prbs31_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        din;
  logic        din_valid;
  logic        err_clr;
  logic        locked_a, pulse_a;
  logic [15:0] cnt_a;
  logic        locked_b, pulse_b;
  logic [3:0]  cnt_b;

  always #5 clk = ~clk;

  prbs31_checker u_dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .err_clr   (err_clr),
    .locked    (locked_a),
    .err_pulse (pulse_a),
    .err_count (cnt_a)
  );

  prbs31_checker #(
    .LOCK_THRESH (64),
    .WIN_LEN     (256),
    .LOSS_THRESH (256),
    .ERR_W       (4)
  ) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .err_clr   (err_clr),
    .locked    (locked_b),
    .err_pulse (pulse_b),
    .err_count (cnt_b)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: 0 = seeding, 1 = verifying, 2 = locked.
  bit hist [2][31];  // index 30 is the newest received bit
  int mode [2];
  int fill [2];
  int good [2];
  int win  [2];
  int werr [2];
  int errc [2];
  bit pulse[2];
  int p_lock[2];
  int p_win [2];
  int p_loss[2];
  int p_max [2];

  logic [17:0] exp_a[$];
  logic [17:0] exp_b[$];

  bit gen[31];  // pattern generator history, index 30 newest
  int nvalid;
  int lock_bit;
  bit seen_lock;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 31; k++) hist[i][k] = 1'b0;
      mode[i]  = 0;
      fill[i]  = 0;
      good[i]  = 0;
      win[i]   = 0;
      werr[i]  = 0;
      errc[i]  = 0;
      pulse[i] = 1'b0;
    end
  endfunction

  function automatic void model_step(int i, bit d, bit v, bit c);
    bit pred, mism, allz, inc;
    inc      = 1'b0;
    pulse[i] = 1'b0;
    if (v) begin
      // x(n) = x(n-28) ^ x(n-31)
      pred = hist[i][3] ^ hist[i][0];
      mism = (d != pred);
      for (int k = 0; k < 30; k++) hist[i][k] = hist[i][k+1];
      hist[i][30] = d;
      allz = 1'b1;
      for (int k = 0; k < 31; k++) if (hist[i][k]) allz = 1'b0;
      case (mode[i])
        0: begin
          fill[i]++;
          if (fill[i] == 31) begin
            mode[i] = 1;
            good[i] = 0;
          end
        end
        1: begin
          if (mism) begin
            mode[i] = 0;
            fill[i] = 0;
          end else begin
            good[i]++;
            if (good[i] == p_lock[i]) begin
              if (allz) begin
                mode[i] = 0;
                fill[i] = 0;
              end else begin
                mode[i] = 2;
                win[i]  = 0;
                werr[i] = 0;
              end
            end
          end
        end
        default: begin
          win[i]++;
          if (mism) begin
            pulse[i] = 1'b1;
            inc      = 1'b1;
            werr[i]++;
          end
          if (werr[i] == p_loss[i]) begin
            mode[i] = 0;
            fill[i] = 0;
          end else if (win[i] == p_win[i]) begin
            win[i]  = 0;
            werr[i] = 0;
          end
        end
      endcase
    end
    if (c) errc[i] = 0;
    else if (inc && errc[i] < p_max[i]) errc[i]++;
  endfunction

  function automatic logic [17:0] model_out(int i);
    model_out = {(mode[i] == 2), pulse[i], 16'(errc[i])};
  endfunction

  function automatic bit gen_next();
    bit b;
    b = gen[3] ^ gen[0];
    for (int k = 0; k < 30; k++) gen[k] = gen[k+1];
    gen[30] = b;
    return b;
  endfunction

  function automatic void gen_seed();
    for (int k = 0; k < 31; k++) gen[k] = 1'b0;
    gen[0] = 1'b1;
  endfunction

  task automatic drive(bit d, bit v, bit c);
    @(negedge clk);
    din       = d;
    din_valid = v;
    err_clr   = c;
    if (v) nvalid++;
    model_step(0, d, v, c);
    model_step(1, d, v, c);
    exp_a.push_back(model_out(0));
    exp_b.push_back(model_out(1));
  endtask

  // n cycles of clean pattern; duty is the percentage of valid cycles.
  task automatic prbs(int n, int duty);
    bit v;
    for (int j = 0; j < n; j++) begin
      v = ($urandom_range(99) < duty);
      if (v) drive(gen_next(), 1'b1, 1'b0);
      else   drive(1'($urandom), 1'b0, 1'b0);
    end
  endtask

  task automatic flip(bit c);
    drive(gen_next() ^ 1'b1, 1'b1, c);
  endtask

  // Asynchronous reset applied between edges, outputs checked while it is held.
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n     = 1'b1;
    din_valid = 1'b0;
    err_clr   = 1'b0;
    #1;
    chk("rst_locked_a", locked_a, 0);
    chk("rst_pulse_a", pulse_a, 0);
    chk("rst_count_a", cnt_a, 0);
    chk("rst_count_b", cnt_b, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    gen_seed();
    nvalid    = 0;
    seen_lock = 1'b0;
    lock_bit  = -1;
  endtask

  // Monitor: compare each DUT against its scoreboard entry just after the edge.
  always @(posedge clk) begin
    logic [17:0] e;
    #1;
    if (exp_a.size() > 0) begin
      e = exp_a.pop_front();
      chk("a_locked", locked_a, e[17]);
      chk("a_err_pulse", pulse_a, e[16]);
      chk("a_err_count", cnt_a, e[15:0]);
      if (locked_a && !seen_lock) begin
        seen_lock = 1'b1;
        lock_bit  = nvalid;
      end
    end
    if (exp_b.size() > 0) begin
      e = exp_b.pop_front();
      chk("b_locked", locked_b, e[17]);
      chk("b_err_pulse", pulse_b, e[16]);
      chk("b_err_count", cnt_b, e[3:0]);
    end
  end

  initial begin
    rst_n     = 1'b1;
    din       = 1'b0;
    din_valid = 1'b0;
    err_clr   = 1'b0;
    p_lock[0] = 64;  p_win[0] = 256; p_loss[0] = 8;   p_max[0] = 65535;
    p_lock[1] = 64;  p_win[1] = 256; p_loss[1] = 256; p_max[1] = 15;
    model_reset();
    gen_seed();

    // Clean lock with continuous valid.
    do_reset();
    prbs(10000, 100);
    chk("clean_lock_bit", lock_bit, 95);

    // Single error, then an error coinciding with err_clr.
    flip(1'b0);
    prbs(5, 100);
    @(posedge clk);
    #2;
    chk("single_err_count", cnt_a, 1);
    chk("single_err_locked", locked_a, 1);
    prbs(40, 100);
    flip(1'b1);
    prbs(300, 100);

    // Loss of lock: eight closely spaced errors, then relock on clean data.
    for (int j = 0; j < 8; j++) begin
      flip(1'b0);
      prbs(1, 100);
    end
    prbs(300, 100);

    // Gapped valid at 50% duty.
    do_reset();
    prbs(600, 50);
    chk("gapped_lock_bit", lock_bit, 95);

    // All-zero stream must never lock.
    do_reset();
    for (int j = 0; j < 1000; j++) drive(1'b0, 1'b1, 1'b0);
    chk("zero_never_locked", seen_lock, 0);

    // Saturation of the narrow counter with isolated errors.
    do_reset();
    prbs(200, 100);
    for (int j = 0; j < 20; j++) begin
      flip(1'b0);
      prbs(49, 100);
    end
    @(posedge clk);
    #2;
    chk("sat_count_b", cnt_b, 15);

    // Random err_clr sprinkled over a locked gapped stream.
    for (int j = 0; j < 400; j++) begin
      if ($urandom_range(15) == 0) flip(1'($urandom_range(1)));
      else if ($urandom_range(1) == 0) drive(gen_next(), 1'b1, ($urandom_range(31) == 0));
      else drive(1'($urandom), 1'b0, ($urandom_range(31) == 0));
    end

    // Mid-operation reset.
    do_reset();
    repeat (3) @(posedge clk);
    #2;
    chk("drain_a", exp_a.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
